// File: rtl/mux21_pkg.sv
// Shared types and defaults for the 2:1 stream merger.
package mux21_pkg;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

   localparam int MUX21_W_DEFAULT = 8;

endpackage

// File: rtl/mux21_rr_arb2.sv
// Two-requester arbiter with one-hot grant, gated by en.
// Define MUX21_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module rr_arb2
   import mux21_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

`ifdef MUX21_FIXED_PRIO_EN
   logic unused_clk_rst;
   assign unused_clk_rst = clk | rst;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req[0])      gnt = 2'b01;
         else if (req[1]) gnt = 2'b10;
      end
   end
`else
   sel_e last_q, last_d;

   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie, favour whoever was not served last.
            2'b11:   gnt = (last_q == SEL_A) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
         if (gnt[1])      last_d = SEL_B;
         else if (gnt[0]) last_d = SEL_A;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= SEL_B;
      else     last_q <= last_d;
   end
`endif

endmodule

// File: rtl/mux21_stream.sv
// 2:1 stream merger: arbitrates a/b into one registered output with source tag s.
// Arbitration is round-robin unless MUX21_FIXED_PRIO_EN is defined.
module mux21_stream
   import mux21_pkg::*;
#(
   parameter int W = MUX21_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a_valid,
   input  logic [W-1:0] a_data,
   output logic         a_ready,
   input  logic         b_valid,
   input  logic [W-1:0] b_data,
   output logic         b_ready,
   output logic         i_valid,
   output logic [W-1:0] i_data,
   output logic         s,
   input  logic         i_ready
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   sel_e         s_q, s_d;
   logic         load;
   logic [1:0]   gnt;

   // Readys are forced low while reset is held, even though the register is empty.
   assign load = (~valid_q | i_ready) & ~rst;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({b_valid, a_valid}),
      .en  (load),
      .gnt (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      s_d     = s_q;
      if (load) begin
         if (gnt[1]) begin
            valid_d = 1'b1;
            data_d  = b_data;
            s_d     = SEL_B;
         end else if (gnt[0]) begin
            valid_d = 1'b1;
            data_d  = a_data;
            s_d     = SEL_A;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         s_q     <= SEL_A;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         s_q     <= s_d;
      end
   end

   assign i_valid = valid_q;
   assign i_data  = data_q;
   assign s       = s_q;

endmodule
